// File: rtl/hdmi_period_scheduler_pkg.sv
// Shared codes, lengths and types for the HDMI TMDS period scheduler.
package hdmi_pkg;

    localparam int unsigned HCNT_W = 12;
    localparam int unsigned VCNT_W = 11;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned PKTS_W = 5;

    localparam logic [1:0] ENC_CTRL  = 2'b00;
    localparam logic [1:0] ENC_DATA  = 2'b10;
    localparam logic [1:0] ENC_VIDEO = 2'b01;

    // {CTL3,CTL2,CTL1,CTL0} during the preamble that announces each period
    localparam logic [3:0] PRE_VIDEO  = 4'b0001;
    localparam logic [3:0] PRE_ISLAND = 4'b0101;

    localparam int unsigned PRE_LEN  = 8;
    localparam int unsigned GB_LEN   = 2;
    localparam int unsigned PKT_LEN  = 32;
    localparam int unsigned CTRL_MIN = 12;

    typedef enum logic [2:0] {
        ST_CTRL,
        ST_VID_PRE,
        ST_VID_GB,
        ST_VIDEO,
        ST_DI_PRE,
        ST_DI_GB_LEAD,
        ST_DI_DATA,
        ST_DI_GB_TRAIL
    } state_e;

    typedef struct packed {
        logic [1:0] enc_state;
        logic [1:0] ch1_ctl;
        logic [1:0] ch2_ctl;
        logic       di_first;
        logic       guard_band;
        logic       gb_island;
        logic       pkt_rd;
        logic       pkt_last;
        logic       pix_req;
    } sched_out_t;

endpackage

// File: rtl/hdmi_period_scheduler_if.sv
// Source/encoder-facing signals of the period scheduler.
interface hdmi_period_scheduler_if;
    import hdmi_pkg::*;

    logic              di_en;
    logic              pkt_valid;
    logic              pkt_rd;
    logic              pkt_last;
    logic              pix_req;
    logic [1:0]        enc_state;
    logic [1:0]        ch0_ctl;
    logic [1:0]        ch1_ctl;
    logic [1:0]        ch2_ctl;
    logic              di_first;
    logic              guard_band;
    logic              gb_island;
    logic [HCNT_W-1:0] hcount;
    logic [VCNT_W-1:0] vcount;

    // master: the scheduler itself
    modport master (
        input  di_en, pkt_valid,
        output pkt_rd, pkt_last, pix_req, enc_state, ch0_ctl, ch1_ctl, ch2_ctl,
               di_first, guard_band, gb_island, hcount, vcount
    );

    // slave: packet/pixel sources and the encoder side
    modport slave (
        output di_en, pkt_valid,
        input  pkt_rd, pkt_last, pix_req, enc_state, ch0_ctl, ch1_ctl, ch2_ctl,
               di_first, guard_band, gb_island, hcount, vcount
    );

endinterface

// File: rtl/hdmi_period_scheduler_raster.sv
// Horizontal/vertical raster counters with registered sync outputs aligned to the counters.
module hdmi_raster_counter
    import hdmi_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned HS_POL   = 0,
    parameter int unsigned VS_POL   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [HCNT_W-1:0] o_hcount,
    output logic [VCNT_W-1:0] o_vcount,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic [HCNT_W-1:0] o_hnext_c,
    output logic              o_next_line_active_c
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic        HS_IDLE = 1'(HS_POL == 0);
    localparam logic        VS_IDLE = 1'(VS_POL == 0);

    logic [HCNT_W-1:0] r_h;
    logic [HCNT_W-1:0] w_h_next;
    logic [VCNT_W-1:0] r_v;
    logic [VCNT_W-1:0] w_v_next;
    logic [VCNT_W-1:0] w_v_after;
    logic              w_h_wrap;
    logic              w_hs_act;
    logic              w_vs_act;
    logic              r_hsync;
    logic              r_vsync;

    // Syncs are decoded from the next counter values so they line up with hcount/vcount
    always_comb begin
        w_h_wrap  = (r_h == HCNT_W'(H_TOTAL - 1));
        w_v_after = (r_v == VCNT_W'(V_TOTAL - 1)) ? '0 : r_v + VCNT_W'(1);
        w_h_next  = w_h_wrap ? '0 : r_h + HCNT_W'(1);
        w_v_next  = w_h_wrap ? w_v_after : r_v;
        w_hs_act  = (w_h_next >= HCNT_W'(H_ACTIVE + H_FP)) &&
                    (w_h_next <  HCNT_W'(H_ACTIVE + H_FP + H_SYNC));
        w_vs_act  = (w_v_next >= VCNT_W'(V_ACTIVE + V_FP)) &&
                    (w_v_next <  VCNT_W'(V_ACTIVE + V_FP + V_SYNC));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h     <= '0;
            r_v     <= '0;
            r_hsync <= HS_IDLE;
            r_vsync <= VS_IDLE;
        end else begin
            r_h     <= w_h_next;
            r_v     <= w_v_next;
            r_hsync <= w_hs_act ? ~HS_IDLE : HS_IDLE;
            r_vsync <= w_vs_act ? ~VS_IDLE : VS_IDLE;
        end
    end

    assign o_hcount             = r_h;
    assign o_vcount             = r_v;
    assign o_hsync              = r_hsync;
    assign o_vsync              = r_vsync;
    assign o_hnext_c            = w_h_next;
    assign o_next_line_active_c = (w_v_after < VCNT_W'(V_ACTIVE));

endmodule

// File: rtl/hdmi_period_scheduler.sv
// HDMI TMDS period scheduler: sequences control, video and data-island periods
// for the three encoder channels and paces the pixel and packet sources.
module hdmi_period_scheduler
    import hdmi_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned HS_POL   = 0,
    parameter int unsigned VS_POL   = 0,
    parameter int unsigned DI_START = 656,
    parameter int unsigned MAX_PKTS = 2
) (
    input  logic                    clklow,
    input  logic                    reset,
    hdmi_period_scheduler_if.master io_sched
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;

    // The longest island plus a minimum control period must finish before the video preamble
    if ((DI_START + PRE_LEN + GB_LEN + PKT_LEN * MAX_PKTS + GB_LEN + CTRL_MIN >
         H_TOTAL - PRE_LEN - GB_LEN) || (MAX_PKTS < 1) || (MAX_PKTS > 18) ||
        (H_BP < PRE_LEN + GB_LEN + CTRL_MIN)) begin : g_bad_timing
        $error("hdmi_period_scheduler: island/blanking timing does not fit the line");
    end

    logic [HCNT_W-1:0] w_hcount;
    logic [HCNT_W-1:0] w_hnext;
    logic [VCNT_W-1:0] w_vcount;
    logic              w_hsync;
    logic              w_vsync;
    logic              w_next_line_active;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [PKTS_W-1:0] r_pkts;
    logic [PKTS_W-1:0] w_pkts_nxt;
    sched_out_t        r_out;
    sched_out_t        w_out;

    hdmi_raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HS_POL   (HS_POL),
        .VS_POL   (VS_POL)
    ) u_raster (
        .clk                  (clklow),
        .rst_n                (reset),
        .o_hcount             (w_hcount),
        .o_vcount             (w_vcount),
        .o_hsync              (w_hsync),
        .o_vsync              (w_vsync),
        .o_hnext_c            (w_hnext),
        .o_next_line_active_c (w_next_line_active)
    );

    always_ff @(posedge clklow or negedge reset) begin
        if (!reset) begin
            r_state <= ST_CTRL;
            r_cnt   <= '0;
            r_pkts  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pkts  <= w_pkts_nxt;
        end
    end

    // Next period is chosen one clock early so the registered outputs match hcount
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_pkts_nxt  = r_pkts;

        case (r_state)
            ST_CTRL: begin
                w_cnt_nxt = '0;
                if (w_hcount == HCNT_W'(H_TOTAL - PRE_LEN - GB_LEN - 1) && w_next_line_active)
                    w_state_nxt = ST_VID_PRE;
                else if (w_hcount == HCNT_W'(DI_START - 1) && io_sched.di_en && io_sched.pkt_valid)
                    w_state_nxt = ST_DI_PRE;
            end
            ST_VID_PRE: if (r_cnt == CNT_W'(PRE_LEN - 1)) begin
                w_state_nxt = ST_VID_GB;
                w_cnt_nxt   = '0;
            end
            ST_VID_GB: if (r_cnt == CNT_W'(GB_LEN - 1)) begin
                w_state_nxt = ST_VIDEO;
                w_cnt_nxt   = '0;
            end
            ST_VIDEO: begin
                w_cnt_nxt = '0;
                if (w_hcount == HCNT_W'(H_ACTIVE - 1))
                    w_state_nxt = ST_CTRL;
            end
            ST_DI_PRE: if (r_cnt == CNT_W'(PRE_LEN - 1)) begin
                w_state_nxt = ST_DI_GB_LEAD;
                w_cnt_nxt   = '0;
            end
            ST_DI_GB_LEAD: if (r_cnt == CNT_W'(GB_LEN - 1)) begin
                w_state_nxt = ST_DI_DATA;
                w_cnt_nxt   = '0;
                w_pkts_nxt  = PKTS_W'(1);
            end
            ST_DI_DATA: if (r_cnt == CNT_W'(PKT_LEN - 1)) begin
                w_cnt_nxt = '0;
                if (io_sched.pkt_valid && (r_pkts < PKTS_W'(MAX_PKTS)))
                    w_pkts_nxt = r_pkts + PKTS_W'(1);
                else
                    w_state_nxt = ST_DI_GB_TRAIL;
            end
            ST_DI_GB_TRAIL: if (r_cnt == CNT_W'(GB_LEN - 1)) begin
                w_state_nxt = ST_CTRL;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_CTRL;
                w_cnt_nxt   = '0;
            end
        endcase

        w_out           = '0;
        w_out.enc_state = ENC_CTRL;
        case (w_state_nxt)
            ST_VID_PRE: begin
                w_out.ch1_ctl = PRE_VIDEO[1:0];
                w_out.ch2_ctl = PRE_VIDEO[3:2];
            end
            ST_VID_GB: begin
                w_out.enc_state  = ENC_VIDEO;
                w_out.guard_band = 1'b1;
                w_out.pix_req    = (w_cnt_nxt == CNT_W'(GB_LEN - 1));
            end
            ST_VIDEO: begin
                w_out.enc_state = ENC_VIDEO;
                w_out.pix_req   = (w_hnext != HCNT_W'(H_ACTIVE - 1));
            end
            ST_DI_PRE: begin
                w_out.ch1_ctl = PRE_ISLAND[1:0];
                w_out.ch2_ctl = PRE_ISLAND[3:2];
            end
            ST_DI_GB_LEAD, ST_DI_GB_TRAIL: begin
                w_out.enc_state  = ENC_DATA;
                w_out.guard_band = 1'b1;
                w_out.gb_island  = 1'b1;
            end
            ST_DI_DATA: begin
                w_out.enc_state = ENC_DATA;
                w_out.pkt_rd    = 1'b1;
                w_out.pkt_last  = (w_cnt_nxt == CNT_W'(PKT_LEN - 1));
                w_out.di_first  = !((w_cnt_nxt == '0) && (w_pkts_nxt == PKTS_W'(1)));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clklow or negedge reset) begin
        if (!reset) r_out <= '0;
        else        r_out <= w_out;
    end

    assign io_sched.enc_state  = r_out.enc_state;
    assign io_sched.ch0_ctl    = {w_vsync, w_hsync};
    assign io_sched.ch1_ctl    = r_out.ch1_ctl;
    assign io_sched.ch2_ctl    = r_out.ch2_ctl;
    assign io_sched.di_first   = r_out.di_first;
    assign io_sched.guard_band = r_out.guard_band;
    assign io_sched.gb_island  = r_out.gb_island;
    assign io_sched.pkt_rd     = r_out.pkt_rd;
    assign io_sched.pkt_last   = r_out.pkt_last;
    assign io_sched.pix_req    = r_out.pix_req;
    assign io_sched.hcount     = w_hcount;
    assign io_sched.vcount     = w_vcount;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Directed bench for hdmi_period_scheduler with a shortened vertical raster.
module tb_hdmi_period_scheduler;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 4;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 2;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errors  = 0;
    int   th = 0;
    int   tv = 0;
    bit   fresh = 1'b1;

    hdmi_period_scheduler_if bus();

    hdmi_period_scheduler #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HS_POL (0), .VS_POL (0), .DI_START (656), .MAX_PKTS (2)
    ) dut (
        .clklow   (clk),
        .reset    (rst_n),
        .io_sched (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
        $fatal(1);
    end

    // {enc_state, ch1, ch2, di_first, guard_band, gb_island, pkt_rd, pkt_last, pix_req}
    function automatic logic [11:0] obs();
        return {bus.enc_state, bus.ch1_ctl, bus.ch2_ctl, bus.di_first, bus.guard_band,
                bus.gb_island, bus.pkt_rd, bus.pkt_last, bus.pix_req};
    endfunction

    function automatic logic [1:0] exp_sync(input int h, input int v);
        logic hs, vs;
        hs = !(h >= 656 && h < 752);
        vs = !(v >= 6 && v < 8);
        return {vs, hs};
    endfunction

    function automatic logic [11:0] exp_raster(input int h, input int v, input bit fr);
        int   vn;
        logic pre, gb, vid, pix;
        vn  = (v + 1) % V_TOTAL;
        pre = (h >= 790 && h <= 797 && vn < V_ACTIVE);
        gb  = (h >= 798 && vn < V_ACTIVE);
        vid = (h < 640 && v < V_ACTIVE && !(fr && v == 0));
        pix = (gb && h == 799) || (vid && h < 639);
        return {(gb || vid) ? 2'b01 : 2'b00, pre ? 2'b01 : 2'b00, 2'b00,
                1'b0, gb, 1'b0, 1'b0, 1'b0, pix};
    endfunction

    // Expected outputs for hcount 640..780 when an island carries npk packets
    function automatic logic [11:0] exp_island(input int h, input int npk);
        logic [11:0] e;
        int          dend;
        e    = 12'h000;
        dend = 666 + 32 * npk;
        if (npk == 0)                 e = 12'h000;
        else if (h >= 656 && h < 664) e = {2'b00, 2'b01, 2'b01, 6'b000000};
        else if (h >= 664 && h < 666) e = {2'b10, 4'b0000, 6'b011000};
        else if (h >= 666 && h < dend)
            e = {2'b10, 4'b0000, (h != 666), 2'b00, 1'b1, ((h - 666) % 32 == 31), 1'b0};
        else if (h >= dend && h < dend + 2) e = {2'b10, 4'b0000, 6'b011000};
        return e;
    endfunction

    task automatic tick();
        @(negedge clk);
        th++;
        if (th == H_TOTAL) begin
            th = 0;
            tv = (tv + 1) % V_TOTAL;
            if (tv != 0) fresh = 1'b0;
        end
    endtask

    task automatic run_to(input int h);
        while (th != h) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.di_en = 1'b0;
        bus.pkt_valid = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (bus.hcount !== 12'd0) begin errors++; $display("FAIL reset_hcount: got %0d want 0", bus.hcount); end
        vectors++; if (bus.vcount !== 11'd0) begin errors++; $display("FAIL reset_vcount: got %0d want 0", bus.vcount); end
        vectors++; if (bus.ch0_ctl !== 2'b11) begin errors++; $display("FAIL reset_sync: got %b want 11", bus.ch0_ctl); end
        vectors++; if (obs() !== 12'h000) begin errors++; $display("FAIL reset_outputs: got %03h want 000", obs()); end
        rst_n = 1'b1;
        th = 0; tv = 0; fresh = 1'b1;
    endtask

    task automatic test_raster();
        repeat (2 * H_TOTAL * V_TOTAL) begin
            tick();
            vectors++;
            if (bus.hcount !== 12'(th) || bus.vcount !== 11'(tv)) begin
                errors++; $display("FAIL raster_count: got h=%0d v=%0d want h=%0d v=%0d", bus.hcount, bus.vcount, th, tv);
            end
            vectors++;
            if (bus.ch0_ctl !== exp_sync(th, tv)) begin
                errors++; $display("FAIL raster_sync h=%0d v=%0d: got %b want %b", th, tv, bus.ch0_ctl, exp_sync(th, tv));
            end
            vectors++;
            if (obs() !== exp_raster(th, tv, fresh)) begin
                errors++; $display("FAIL raster_period h=%0d v=%0d: got %03h want %03h", th, tv, obs(), exp_raster(th, tv, fresh));
            end
        end
    endtask

    task automatic test_single_packet();
        bus.di_en = 1'b1;
        run_to(640);
        while (th <= 780) begin
            vectors++;
            if (obs() !== exp_island(th, 1)) begin
                errors++; $display("FAIL single_pkt h=%0d v=%0d: got %03h want %03h", th, tv, obs(), exp_island(th, 1));
            end
            vectors++;
            if (bus.ch0_ctl !== exp_sync(th, tv)) begin
                errors++; $display("FAIL single_pkt_sync h=%0d: got %b want %b", th, bus.ch0_ctl, exp_sync(th, tv));
            end
            if (th == 655) bus.pkt_valid = 1'b1;
            if (th == 656) bus.pkt_valid = 1'b0;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        run_to(640);
        while (th <= 780) begin
            vectors++;
            if (obs() !== exp_island(th, 2)) begin
                errors++; $display("FAIL back_to_back h=%0d v=%0d: got %03h want %03h", th, tv, obs(), exp_island(th, 2));
            end
            vectors++;
            if (bus.ch0_ctl !== exp_sync(th, tv)) begin
                errors++; $display("FAIL back_to_back_sync h=%0d: got %b want %b", th, bus.ch0_ctl, exp_sync(th, tv));
            end
            if (th == 650) bus.pkt_valid = 1'b1;
            if (th == 780) bus.pkt_valid = 1'b0;
            tick();
        end
    endtask

    task automatic test_drop_mid();
        run_to(640);
        while (th <= 780) begin
            vectors++;
            if (obs() !== exp_island(th, 1)) begin
                errors++; $display("FAIL drop_mid h=%0d v=%0d: got %03h want %03h", th, tv, obs(), exp_island(th, 1));
            end
            if (th == 650) bus.pkt_valid = 1'b1;
            if (th == 670) bus.pkt_valid = 1'b0;
            tick();
        end
    endtask

    task automatic test_late_valid();
        for (int ln = 0; ln < 2; ln++) begin
            run_to(640);
            while (th <= 780) begin
                vectors++;
                if (obs() !== exp_island(th, (ln == 0) ? 0 : 2)) begin
                    errors++; $display("FAIL late_valid line%0d h=%0d: got %03h want %03h", ln, th, obs(), exp_island(th, (ln == 0) ? 0 : 2));
                end
                if (ln == 0 && th == 656) bus.pkt_valid = 1'b1;
                if (ln == 1 && th == 700) bus.pkt_valid = 1'b0;
                tick();
            end
        end
    endtask

    task automatic test_di_disabled();
        bus.di_en = 1'b0;
        bus.pkt_valid = 1'b1;
        run_to(640);
        while (th <= 780) begin
            vectors++;
            if (obs() !== 12'h000) begin
                errors++; $display("FAIL di_disabled h=%0d: got %03h want 000", th, obs());
            end
            tick();
        end
        bus.pkt_valid = 1'b0;
        bus.di_en = 1'b1;
    endtask

    task automatic test_reset_mid_island();
        bus.di_en = 1'b1;
        run_to(640);
        while (th <= 680) begin
            vectors++;
            if (obs() !== exp_island(th, 2)) begin
                errors++; $display("FAIL pre_reset_island h=%0d: got %03h want %03h", th, obs(), exp_island(th, 2));
            end
            if (th == 650) bus.pkt_valid = 1'b1;
            if (th == 680) break;
            tick();
        end
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.hcount !== 12'd0) begin errors++; $display("FAIL midreset_hcount: got %0d want 0", bus.hcount); end
        vectors++; if (bus.vcount !== 11'd0) begin errors++; $display("FAIL midreset_vcount: got %0d want 0", bus.vcount); end
        vectors++; if (bus.ch0_ctl !== 2'b11) begin errors++; $display("FAIL midreset_sync: got %b want 11", bus.ch0_ctl); end
        vectors++; if (obs() !== 12'h000) begin errors++; $display("FAIL midreset_outputs: got %03h want 000", obs()); end
        @(negedge clk);
        bus.pkt_valid = 1'b0;
        rst_n = 1'b1;
        th = 0; tv = 0; fresh = 1'b1;
        repeat (1000) begin
            tick();
            vectors++;
            if (bus.hcount !== 12'(th) || bus.vcount !== 11'(tv)) begin
                errors++; $display("FAIL restart_count: got h=%0d v=%0d want h=%0d v=%0d", bus.hcount, bus.vcount, th, tv);
            end
            vectors++;
            if (obs() !== exp_raster(th, tv, fresh)) begin
                errors++; $display("FAIL restart_period h=%0d v=%0d: got %03h want %03h", th, tv, obs(), exp_raster(th, tv, fresh));
            end
        end
    endtask

    initial begin
        test_reset();
        test_raster();
        test_single_packet();
        test_back_to_back();
        test_drop_mid();
        test_late_valid();
        test_di_disabled();
        test_reset_mid_island();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
